// File: rtl/microwave_ctrl_if.sv
// Front-panel and countdown-timer signal bundle of the microwave controller.
// The controller uses the slave modport; the panel/timer side uses master.
interface microwave_ctrl_if;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop_clr;
    logic       door_closed;
    logic       zero;
    logic [3:0] sec_units;
    logic [3:0] sec_tens;
    logic [3:0] minutes;
    logic       load;
    logic       enable;
    logic       timer_clear;
    logic       mag_on;
    logic       done;
    logic       beep;
    logic       key_err;

    modport master (
        output key_valid, key_digit, start, stop_clr, door_closed, zero,
        input  sec_units, sec_tens, minutes, load, enable, timer_clear,
               mag_on, done, beep, key_err
    );

    modport slave (
        input  key_valid, key_digit, start, stop_clr, door_closed, zero,
        output sec_units, sec_tens, minutes, load, enable, timer_clear,
               mag_on, done, beep, key_err
    );
endinterface

// File: rtl/microwave_ctrl.sv
// Microwave front-panel controller: M:SS key entry, timer load/count/pause/clear, done and beeper.
// Optional macro QUICK_START_EN: start on an empty buffer loads 0:30 and starts cooking.
module microwave_ctrl #(
    parameter int unsigned BEEP_CYCLES = 3
) (
    input logic             clk,
    input logic             clear,
    microwave_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] BEEP_LAST = 8'(BEEP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] units_q, units_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] min_q, min_d;
    logic [7:0] beep_cnt_q, beep_cnt_d;
    logic       door_q;
    logic       load_q, load_d;
    logic       enable_q, enable_d;
    logic       mag_on_q;
    logic       timer_clear_q, timer_clear_d;
    logic       done_q, done_d;
    logic       beep_q, beep_d;
    logic       key_err_q, key_err_d;
    logic       buf_zero;
    logic       door_fall;

    // A digit is refused if it is not BCD or if the current units digit could not become a tens digit.
    function automatic logic key_rejected(input logic [3:0] digit, input logic [3:0] units);
        return (digit > 4'd9) || (units > 4'd5);
    endfunction

    assign buf_zero  = (units_q == 4'd0) && (tens_q == 4'd0) && (min_q == 4'd0);
    assign door_fall = door_q && !bus.door_closed;

    // Next-state, buffer and output-pulse decode.
    always_comb begin
        state_d       = state_q;
        units_d       = units_q;
        tens_d        = tens_q;
        min_d         = min_q;
        timer_clear_d = 1'b0;
        key_err_d     = 1'b0;
        beep_cnt_d    = 8'd0;
        beep_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.stop_clr) begin
                    state_d = ST_IDLE;
                end else if (bus.start && bus.door_closed && !buf_zero) begin
                    state_d = ST_LOAD;
`ifdef QUICK_START_EN
                end else if (bus.start && bus.door_closed) begin
                    min_d   = 4'd0;
                    tens_d  = 4'd3;
                    units_d = 4'd0;
                    state_d = ST_LOAD;
`endif
                end else if (bus.key_valid) begin
                    if (key_rejected(bus.key_digit, units_q)) begin
                        key_err_d = 1'b1;
                    end else begin
                        min_d   = tens_q;
                        tens_d  = units_q;
                        units_d = bus.key_digit;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_COOK;
            end
            ST_COOK: begin
                if (bus.stop_clr || !bus.door_closed) begin
                    state_d = ST_PAUSE;
                end else if (bus.zero) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_COOK;
                end
            end
            ST_PAUSE: begin
                if (bus.stop_clr) begin
                    state_d       = ST_IDLE;
                    timer_clear_d = 1'b1;
                    min_d         = 4'd0;
                    tens_d        = 4'd0;
                    units_d       = 4'd0;
                end else if (bus.start && bus.door_closed) begin
                    state_d = ST_COOK;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (bus.stop_clr || door_fall) begin
                    state_d       = ST_IDLE;
                    timer_clear_d = 1'b1;
                end else if (bus.start && bus.door_closed && !buf_zero) begin
                    state_d = ST_LOAD;
                end else if (bus.key_valid) begin
                    // A new entry after cooking starts from an empty buffer.
                    state_d = ST_IDLE;
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    if (key_rejected(bus.key_digit, 4'd0)) begin
                        key_err_d = 1'b1;
                        units_d   = 4'd0;
                    end else begin
                        units_d = bus.key_digit;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_DONE) begin
            if (state_q != ST_DONE) begin
                beep_cnt_d = BEEP_LAST;
                beep_d     = 1'b1;
            end else if (beep_cnt_q != 8'd0) begin
                beep_cnt_d = beep_cnt_q - 8'd1;
                beep_d     = 1'b1;
            end else begin
                beep_cnt_d = 8'd0;
                beep_d     = 1'b0;
            end
        end else begin
            beep_cnt_d = 8'd0;
            beep_d     = 1'b0;
        end

        load_d   = (state_d == ST_LOAD);
        enable_d = (state_d == ST_COOK);
        done_d   = (state_d == ST_DONE);
    end

    // State, buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q       <= ST_IDLE;
            units_q       <= 4'd0;
            tens_q        <= 4'd0;
            min_q         <= 4'd0;
            beep_cnt_q    <= 8'd0;
            door_q        <= 1'b0;
            load_q        <= 1'b0;
            enable_q      <= 1'b0;
            mag_on_q      <= 1'b0;
            timer_clear_q <= 1'b0;
            done_q        <= 1'b0;
            beep_q        <= 1'b0;
            key_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            units_q       <= units_d;
            tens_q        <= tens_d;
            min_q         <= min_d;
            beep_cnt_q    <= beep_cnt_d;
            door_q        <= bus.door_closed;
            load_q        <= load_d;
            enable_q      <= enable_d;
            mag_on_q      <= enable_d;
            timer_clear_q <= timer_clear_d;
            done_q        <= done_d;
            beep_q        <= beep_d;
            key_err_q     <= key_err_d;
        end
    end

    assign bus.sec_units   = units_q;
    assign bus.sec_tens    = tens_q;
    assign bus.minutes     = min_q;
    assign bus.load        = load_q;
    assign bus.enable      = enable_q;
    assign bus.mag_on      = mag_on_q;
    assign bus.timer_clear = timer_clear_q;
    assign bus.done        = done_q;
    assign bus.beep        = beep_q;
    assign bus.key_err     = key_err_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed, table-driven bench for microwave_ctrl plus a few hand-written multi-cycle sequences.
module tb_microwave_ctrl;

    logic clk = 1'b0;
    logic clear;
    microwave_ctrl_if bus ();

    microwave_ctrl #(.BEEP_CYCLES(3)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // flag order: load, enable, timer_clear, mag_on, done, beep, key_err
    localparam logic [6:0] F0  = 7'b0000000;
    localparam logic [6:0] FL  = 7'b1000000;
    localparam logic [6:0] FC  = 7'b0101000;
    localparam logic [6:0] FT  = 7'b0010000;
    localparam logic [6:0] FDB = 7'b0000110;
    localparam logic [6:0] FD  = 7'b0000100;
    localparam logic [6:0] FK  = 7'b0000001;

    typedef struct {
        string       name;
        logic        clr;
        logic        kv;
        logic [3:0]  kd;
        logic        st;
        logic        sc;
        logic        dc;
        logic        z;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [18:0] observed();
        return {bus.minutes, bus.sec_tens, bus.sec_units, bus.load, bus.enable,
                bus.timer_clear, bus.mag_on, bus.done, bus.beep, bus.key_err};
    endfunction

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got m/t/u=%h%h%h flags=%b, want m/t/u=%h%h%h flags=%b",
                     name, got[18:15], got[14:11], got[10:7], got[6:0],
                     exp[18:15], exp[14:11], exp[10:7], exp[6:0]);
        end
    endtask

    task automatic add(input string name, input logic clr, input logic kv, input logic [3:0] kd,
                       input logic st, input logic sc, input logic dc, input logic z,
                       input logic [3:0] m, input logic [3:0] t, input logic [3:0] u,
                       input logic [6:0] f);
        vec_t v;
        v.name = name; v.clr = clr; v.kv = kv; v.kd = kd; v.st = st; v.sc = sc;
        v.dc = dc; v.z = z; v.exp = {m, t, u, f};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic clr, input logic kv, input logic [3:0] kd, input logic st,
                         input logic sc, input logic dc, input logic z);
        @(negedge clk);
        clear           = clr;
        bus.key_valid   = kv;
        bus.key_digit   = kd;
        bus.start       = st;
        bus.stop_clr    = sc;
        bus.door_closed = dc;
        bus.zero        = z;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int beeps;
        int waited;
        clear = 1'b1;
        bus.key_valid = 1'b0; bus.key_digit = 4'd0; bus.start = 1'b0;
        bus.stop_clr = 1'b0; bus.door_closed = 1'b1; bus.zero = 1'b0;

        // name, clr kv kd st sc dc z, m t u, flags
        add("reset",          1, 0, 4'd0,  0, 0, 1, 0, 4'd0, 4'd0, 4'd0, F0);
        add("key1",           0, 1, 4'd1,  0, 0, 1, 0, 4'd0, 4'd0, 4'd1, F0);
        add("key3",           0, 1, 4'd3,  0, 0, 1, 0, 4'd0, 4'd1, 4'd3, F0);
        add("key0",           0, 1, 4'd0,  0, 0, 1, 0, 4'd1, 4'd3, 4'd0, F0);
        add("start_load",     0, 0, 4'd0,  1, 0, 1, 0, 4'd1, 4'd3, 4'd0, FL);
        add("cook_enable",    0, 0, 4'd0,  0, 0, 1, 0, 4'd1, 4'd3, 4'd0, FC);
        add("cook_hold",      0, 0, 4'd0,  0, 0, 1, 0, 4'd1, 4'd3, 4'd0, FC);
        add("clear_midcook",  1, 0, 4'd0,  0, 0, 1, 0, 4'd0, 4'd0, 4'd0, F0);
        add("key2",           0, 1, 4'd2,  0, 0, 1, 0, 4'd0, 4'd0, 4'd2, F0);
        add("key7",           0, 1, 4'd7,  0, 0, 1, 0, 4'd0, 4'd2, 4'd7, F0);
        add("key5_reject",    0, 1, 4'd5,  0, 0, 1, 0, 4'd0, 4'd2, 4'd7, FK);
        add("key_err_drop",   0, 0, 4'd0,  0, 0, 1, 0, 4'd0, 4'd2, 4'd7, F0);
        add("key12_reject",   0, 1, 4'd12, 0, 0, 1, 0, 4'd0, 4'd2, 4'd7, FK);
        add("reset2",         1, 0, 4'd0,  0, 0, 1, 0, 4'd0, 4'd0, 4'd0, F0);
        add("key12_empty",    0, 1, 4'd12, 0, 0, 1, 0, 4'd0, 4'd0, 4'd0, FK);
        add("key9",           0, 1, 4'd9,  0, 0, 1, 0, 4'd0, 4'd0, 4'd9, F0);
        add("start9",         0, 0, 4'd0,  1, 0, 1, 0, 4'd0, 4'd0, 4'd9, FL);
        add("cook9",          0, 0, 4'd0,  0, 0, 1, 0, 4'd0, 4'd0, 4'd9, FC);
        add("door_open",      0, 0, 4'd0,  0, 0, 0, 0, 4'd0, 4'd0, 4'd9, F0);
        add("start_door_open",0, 0, 4'd0,  1, 0, 0, 0, 4'd0, 4'd0, 4'd9, F0);
        add("resume_noload",  0, 0, 4'd0,  1, 0, 1, 0, 4'd0, 4'd0, 4'd9, FC);
        add("key_in_cook",    0, 1, 4'd5,  0, 0, 1, 0, 4'd0, 4'd0, 4'd9, FC);
        add("stop_pause",     0, 0, 4'd0,  0, 1, 1, 0, 4'd0, 4'd0, 4'd9, F0);
        add("stop_over_start",0, 0, 4'd0,  1, 1, 1, 0, 4'd0, 4'd0, 4'd0, FT);
        add("idle_after_clr", 0, 0, 4'd0,  0, 0, 1, 0, 4'd0, 4'd0, 4'd0, F0);
        add("k1",             0, 1, 4'd1,  0, 0, 1, 0, 4'd0, 4'd0, 4'd1, F0);
        add("k0a",            0, 1, 4'd0,  0, 0, 1, 0, 4'd0, 4'd1, 4'd0, F0);
        add("k0b",            0, 1, 4'd0,  0, 0, 1, 0, 4'd1, 4'd0, 4'd0, F0);
        add("start100",       0, 0, 4'd0,  1, 0, 1, 0, 4'd1, 4'd0, 4'd0, FL);
        add("cook100",        0, 0, 4'd0,  0, 0, 1, 0, 4'd1, 4'd0, 4'd0, FC);
        add("zero_done",      0, 0, 4'd0,  0, 0, 1, 1, 4'd1, 4'd0, 4'd0, FDB);
        add("beep2",          0, 0, 4'd0,  0, 0, 1, 0, 4'd1, 4'd0, 4'd0, FDB);
        add("beep3",          0, 0, 4'd0,  0, 0, 1, 0, 4'd1, 4'd0, 4'd0, FDB);
        add("beep_off",       0, 0, 4'd0,  0, 0, 1, 0, 4'd1, 4'd0, 4'd0, FD);
        add("done_hold",      0, 0, 4'd0,  0, 0, 1, 0, 4'd1, 4'd0, 4'd0, FD);
        add("recook_load",    0, 0, 4'd0,  1, 0, 1, 0, 4'd1, 4'd0, 4'd0, FL);
        add("recook",         0, 0, 4'd0,  0, 0, 1, 0, 4'd1, 4'd0, 4'd0, FC);
        add("zero_done2",     0, 0, 4'd0,  0, 0, 1, 1, 4'd1, 4'd0, 4'd0, FDB);
        add("done_stop",      0, 0, 4'd0,  0, 1, 1, 0, 4'd1, 4'd0, 4'd0, FT);
        add("idle_retained",  0, 0, 4'd0,  0, 0, 1, 0, 4'd1, 4'd0, 4'd0, F0);
        add("load_again",     0, 0, 4'd0,  1, 0, 1, 0, 4'd1, 4'd0, 4'd0, FL);
        add("cook_again",     0, 0, 4'd0,  0, 0, 1, 0, 4'd1, 4'd0, 4'd0, FC);
        add("zero_and_stop",  0, 0, 4'd0,  0, 1, 1, 1, 4'd1, 4'd0, 4'd0, F0);
        add("zero_in_pause",  0, 0, 4'd0,  0, 0, 1, 1, 4'd1, 4'd0, 4'd0, F0);
        add("resume2",        0, 0, 4'd0,  1, 0, 1, 0, 4'd1, 4'd0, 4'd0, FC);
        add("door_over_zero", 0, 0, 4'd0,  0, 0, 0, 1, 4'd1, 4'd0, 4'd0, F0);
        add("pause_stop",     0, 0, 4'd0,  0, 1, 1, 0, 4'd0, 4'd0, 4'd0, FT);
        add("key2b",          0, 1, 4'd2,  0, 0, 1, 0, 4'd0, 4'd0, 4'd2, F0);
        add("load2",          0, 0, 4'd0,  1, 0, 1, 0, 4'd0, 4'd0, 4'd2, FL);
        add("cook2",          0, 0, 4'd0,  0, 0, 1, 0, 4'd0, 4'd0, 4'd2, FC);
        add("done2",          0, 0, 4'd0,  0, 0, 1, 1, 4'd0, 4'd0, 4'd2, FDB);
        add("done_door_fall", 0, 0, 4'd0,  0, 0, 0, 0, 4'd0, 4'd0, 4'd2, FT);
        add("door_reclose",   0, 0, 4'd0,  0, 0, 1, 0, 4'd0, 4'd0, 4'd2, F0);
        add("load3",          0, 0, 4'd0,  1, 0, 1, 0, 4'd0, 4'd0, 4'd2, FL);
        add("cook3",          0, 0, 4'd0,  0, 0, 1, 0, 4'd0, 4'd0, 4'd2, FC);
        add("done3",          0, 0, 4'd0,  0, 0, 1, 1, 4'd0, 4'd0, 4'd2, FDB);
        add("done_key_entry", 0, 1, 4'd7,  0, 0, 1, 0, 4'd0, 4'd0, 4'd7, F0);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].kv, vecs[i].kd, vecs[i].st, vecs[i].sc, vecs[i].dc, vecs[i].z);
            check(vecs[i].name, observed(), vecs[i].exp);
        end

        // Start on an empty buffer: quick-start load of 0:30, or nothing at all.
        drive(1, 0, 4'd0, 0, 0, 1, 0);
        drive(0, 0, 4'd0, 1, 0, 1, 0);
`ifdef QUICK_START_EN
        check("empty_start", observed(), {4'd0, 4'd3, 4'd0, FL});
        drive(0, 0, 4'd0, 0, 0, 1, 0);
        check("empty_start_cook", observed(), {4'd0, 4'd3, 4'd0, FC});
`else
        check("empty_start", observed(), {4'd0, 4'd0, 4'd0, F0});
        drive(0, 0, 4'd0, 0, 0, 1, 0);
        check("empty_start_idle", observed(), {4'd0, 4'd0, 4'd0, F0});
`endif

        // Bounded wait for cooking to begin, then count beeper cycles after zero.
        drive(1, 0, 4'd0, 0, 0, 1, 0);
        drive(0, 1, 4'd5, 0, 0, 1, 0);
        drive(0, 0, 4'd0, 1, 0, 1, 0);
        waited = 0;
        while (bus.enable !== 1'b1 && waited < 20) begin
            drive(0, 0, 4'd0, 0, 0, 1, 0);
            waited++;
        end
        check("cook_started", {18'd0, bus.enable}, {18'd0, 1'b1});
        drive(0, 0, 4'd0, 0, 0, 1, 1);
        beeps = (bus.beep === 1'b1) ? 1 : 0;
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 4'd0, 0, 0, 1, 0);
            if (bus.beep === 1'b1) beeps++;
        end
        check("beep_cycles", 19'(beeps), 19'd3);
        check("done_level", observed(), {4'd0, 4'd0, 4'd5, FD});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
